spi_master_engine: RTL
======================

SPI_MASTER_ENGINE -- requirements
Module: spi_master_engine

Interface
REQ-001 DATA_W, 8, bits per frame (≥4).
REQ-002 NUM_CS, 1, chip-select outputs (1..8).
REQ-003 DIV_W, 8, clock-divider input width.
REQ-004 FIFO_DEPTH, 4, RX FIFO entries (power of two, ≥2; used only with SPI_RX_FIFO_EN).
REQ-005 clock  in  1  system clock; all logic on rising edge.
REQ-006 reset_n  in  1  synchronous, active-low reset.
REQ-007 writedata  in  DATA_W  TX frame.
REQ-008 write  in  1  start strobe.
REQ-009 cs_idx  in  max(1,clog2(NUM_CS))  target chip select.
REQ-010 clk_div  in  DIV_W  half SCLK period = clk_div+1 clocks.
REQ-011 cpol, cpha  in  1 each  SPI mode.
REQ-012 keep_cs  in  1  keep CS low after frame.
REQ-013 busy  out  1  frame in progress.
REQ-014 readdata  out  DATA_W  received frame.
REQ-015 rx_valid  out  1  readdata valid.
REQ-016 read  in  1  consume readdata.
REQ-017 rx_overflow  out  1  sticky, RX data lost.
REQ-018 SD_CLK out 1, SD_MOSI out 1, SD_MISO in 1, SD_CS out NUM_CS (active-low).

Function
REQ-019 write with busy=0 SHALL capture writedata, cs_idx, clk_div, cpol, cpha, keep_cs; busy=1 from next cycle; write while busy=1 ignored.
REQ-020 FSM SHALL be IDLE->SETUP (on accept) ->SHIFT->HOLD->IDLE; SETUP and HOLD last one half period each, SHIFT 2*DATA_W half periods.
REQ-021 busy SHALL stay high exactly (2*DATA_W+2)*(clk_div+1) cycles; divider counter reloads every half period.
REQ-022 SD_CS[cs_idx] SHALL go low the cycle after accept; other CS lines high.
REQ-023 SD_CLK SHALL equal cpol in IDLE/SETUP/HOLD and toggle at each half-period boundary in SHIFT.
REQ-024 Frames MSB first; cpha=0: MOSI bit valid at SETUP start, MISO sampled on leading edge, MOSI shifts on trailing edge; cpha=1: MOSI shifts on leading edge, MISO sampled on trailing edge.
REQ-025 End of HOLD: busy=0, received frame delivered, SD_CS all high unless keep_cs=1 (selected line stays low until next frame ends with keep_cs=0).
REQ-026 SD_MOSI SHALL be 1 when idle.
REQ-027 Delivery and read in the same cycle SHALL both succeed, no overflow.
REQ-028 clk_div=0 SHALL give SCLK = clock/2.

Reset
REQ-029 reset_n=0 at a rising edge SHALL force: state IDLE, busy 0, SD_CLK 0, SD_MOSI 1, SD_CS all 1, readdata 0, rx_valid 0, rx_overflow 0, FIFO empty.
REQ-030 Reset mid-frame SHALL abort with no delivery; first post-reset write accepted normally.

Configuration
REQ-031 SPI_RX_FIFO_EN defined: received frames pushed into FIFO_DEPTH FIFO; readdata shows head; rx_valid=!empty; read pops; push when full drops frame and sets rx_overflow; push+pop when full both succeed; read when empty ignored.
REQ-032 SPI_RX_FIFO_EN undefined: single readdata register; delivery sets rx_valid, read clears it; delivery with rx_valid=1 and no read overwrites and sets rx_overflow.

Structure
REQ-033 Package spi_master_pkg SHALL hold FSM state enum, mode encodings, CS-index width function.
REQ-034 FIFO SHALL be sub-module spi_rx_fifo, instantiated only with SPI_RX_FIFO_EN.

Verification
REQ-035 DATA_W=8, clk_div=0, mode 0, MISO looped to MOSI, write 0xA5 -> MOSI 1,0,1,0,0,1,0,1 at SD_CLK rises, readdata 0xA5, busy 18 cycles.
REQ-036 clk_div=3, cpol=1, cpha=1, slave returns 0x3C -> SD_CLK idle high, period 8 clocks, readdata 0x3C, busy 72 cycles.
REQ-037 NUM_CS=2, cs_idx=1, frame keep_cs=1 then keep_cs=0 -> SD_CS=2'b01 between frames, 2'b11 after second.
REQ-038 FIFO enabled, depth 4, five frames 0x01..0x05 no reads -> rx_overflow=1, reads return 0x01..0x04, then rx_valid=0.
REQ-039 reset_n low during SHIFT -> next cycle SD_CS all 1, busy 0, rx_valid 0, no frame delivered.
REQ-040 write 0xFF while busy with 0x5A -> ignored; only 0x5A transmitted, busy length unchanged.

Source files
------------

// File: rtl/spi_master_pkg.sv
// SPI master shared types: FSM states, SPI mode encodings
// and the chip-select index width helper.
package spi_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD
  } spi_state_e;

  // Encoded as {cpol, cpha}.
  typedef enum logic [1:0] {
    MODE0 = 2'b00,
    MODE1 = 2'b01,
    MODE2 = 2'b10,
    MODE3 = 2'b11
  } spi_mode_e;

  function automatic int cs_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_rx_fifo.sv
// Receive FIFO for the SPI master; built only when
// SPI_RX_FIFO_EN is defined.
module spi_rx_fifo
  import spi_master_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              valid,
  output logic              overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              full, empty, do_push, do_pop;

  assign full     = (cnt_q == (AW+1)'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign head     = mem_q[rd_q];
  assign valid    = ~empty;
  assign overflow = ovf_q;

  // A pop frees a slot for a same-cycle push into a full FIFO.
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (do_push) begin
      mem_d[wr_q] = push_data;
      wr_d = wr_q + 1'b1;
    end
    if (do_pop) rd_d = rd_q + 1'b1;
    if (push && !do_push) ovf_d = 1'b1;
    if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
    if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
  end

  // FIFO storage and pointers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: rtl/spi_master_engine.sv
// Single-frame SPI master, all four modes, programmable divider.
// Define SPI_RX_FIFO_EN to buffer received frames in a FIFO.
module spi_master_engine
  import spi_master_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int NUM_CS     = 1,
  parameter int DIV_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [DATA_W-1:0]           writedata,
  input  logic                        write,
  input  logic [cs_idx_w(NUM_CS)-1:0] cs_idx,
  input  logic [DIV_W-1:0]            clk_div,
  input  logic                        cpol,
  input  logic                        cpha,
  input  logic                        keep_cs,
  output logic                        busy,
  output logic [DATA_W-1:0]           readdata,
  output logic                        rx_valid,
  input  logic                        read,
  output logic                        rx_overflow,
  output logic                        SD_CLK,
  output logic                        SD_MOSI,
  input  logic                        SD_MISO,
  output logic [NUM_CS-1:0]           SD_CS
);

  localparam int HW = $clog2(2*DATA_W);
  localparam logic [HW-1:0] HLAST = HW'(2*DATA_W-1);

  spi_state_e        state_q, state_d;
  spi_mode_e         mode_q, mode_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d, div_q, div_d;
  logic [HW-1:0]     hcnt_q, hcnt_d;
  logic [DATA_W-1:0] tx_q, tx_d, rx_q, rx_d;
  logic [NUM_CS-1:0] cs_q, cs_d;
  logic              keep_q, keep_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              busy_q, busy_d;
  logic              tick, edge_hit, lead, deliver;

  assign busy    = busy_q;
  assign SD_CLK  = sclk_q;
  assign SD_MOSI = mosi_q;
  assign SD_CS   = cs_q;
  assign deliver = (state_q == ST_HOLD) && tick;

  // Frame sequencing; an SCLK edge fires at every half-period
  // boundary from SETUP into SHIFT and within SHIFT.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    hcnt_d   = hcnt_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    cs_d     = cs_q;
    keep_d   = keep_q;
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;
    busy_d   = busy_q;
    edge_hit = 1'b0;
    lead     = 1'b0;
    tick     = (cnt_q == '0);
    if (state_q != ST_IDLE)
      cnt_d = tick ? div_q : cnt_q - 1'b1;
    unique case (state_q)
      ST_IDLE: if (write) begin
        state_d = ST_SETUP;
        cnt_d   = clk_div;
        div_d   = clk_div;
        mode_d  = spi_mode_e'({cpol, cpha});
        keep_d  = keep_cs;
        cs_d    = ~(NUM_CS'(1) << cs_idx);
        tx_d    = writedata;
        mosi_d  = writedata[DATA_W-1];
        sclk_d  = cpol;
        busy_d  = 1'b1;
      end
      ST_SETUP: if (tick) begin
        state_d  = ST_SHIFT;
        hcnt_d   = '0;
        edge_hit = 1'b1;
        lead     = 1'b1;
      end
      ST_SHIFT: if (tick) begin
        if (hcnt_q == HLAST) begin
          state_d = ST_HOLD;
        end else begin
          hcnt_d   = hcnt_q + 1'b1;
          edge_hit = 1'b1;
          lead     = hcnt_q[0];
        end
      end
      ST_HOLD: if (tick) begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        mosi_d  = 1'b1;
        if (!keep_q) cs_d = '1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (edge_hit) begin
      sclk_d = ~sclk_q;
      if (lead != mode_q[0]) begin
        rx_d = {rx_q[DATA_W-2:0], SD_MISO};
      end else if (mode_q[0]) begin
        mosi_d = tx_q[DATA_W-1];
        tx_d   = tx_q << 1;
      end else begin
        mosi_d = tx_q[DATA_W-2];
        tx_d   = tx_q << 1;
      end
    end
  end

  // Frame engine registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE0;
      cnt_q   <= '0;
      div_q   <= '0;
      hcnt_q  <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      cs_q    <= '1;
      keep_q  <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      hcnt_q  <= hcnt_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      cs_q    <= cs_d;
      keep_q  <= keep_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
    end
  end

`ifdef SPI_RX_FIFO_EN
  spi_rx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_rx_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (deliver),
    .push_data (rx_q),
    .pop       (read),
    .head      (readdata),
    .valid     (rx_valid),
    .overflow  (rx_overflow)
  );
`else
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              ovf_q, ovf_d;

  assign readdata    = rdata_q;
  assign rx_valid    = rvalid_q;
  assign rx_overflow = ovf_q;

  // Single holding register; unread data is overwritten.
  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = rvalid_q;
    ovf_d    = ovf_q;
    if (deliver) begin
      rdata_d  = rx_q;
      rvalid_d = 1'b1;
      if (rvalid_q && !read) ovf_d = 1'b1;
    end else if (read) begin
      rvalid_d = 1'b0;
    end
  end

  // Holding register state.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      ovf_q    <= ovf_d;
    end
  end
`endif

endmodule
